// File: rtl/short_preamble_gen_pkg.sv
// Shared types, constants and short training symbol tables for short_preamble_gen.
package short_preamble_gen_pkg;

    localparam int unsigned SYM_LEN   = 16;
    localparam int unsigned TBL_WIDTH = 16;
    localparam int unsigned IDX_WIDTH = 4;
    localparam int unsigned SHF_WIDTH = 3;

    typedef logic signed [TBL_WIDTH-1:0] stf_val_t;

    typedef struct packed {
        stf_val_t i;
        stf_val_t q;
    } stf_sample_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_TAIL,
        ST_DONE
    } stf_state_e;

    // Short training symbol, scaled by 2^13
    localparam stf_val_t STF_I [SYM_LEN] = '{
        16'sd377,  -16'sd1081, -16'sd106, 16'sd1171,
        16'sd754,  16'sd1171,  -16'sd106, -16'sd1081,
        16'sd377,  16'sd16,    -16'sd647, -16'sd106,
        16'sd0,    -16'sd106,  -16'sd647, 16'sd16
    };

    localparam stf_val_t STF_Q [SYM_LEN] = '{
        16'sd377,  16'sd16,    -16'sd647, -16'sd106,
        16'sd0,    -16'sd106,  -16'sd647, 16'sd16,
        16'sd377,  -16'sd1081, -16'sd106, 16'sd1171,
        16'sd754,  16'sd1171,  -16'sd106, -16'sd1081
    };

    // Floor scaling of one table component
    function automatic stf_val_t stf_shift(input stf_val_t v, input logic [SHF_WIDTH-1:0] s);
        return v >>> s;
    endfunction

endpackage

// File: rtl/stf_rom.sv
// Combinational lookup of one {I,Q} short training sample by symbol index.
module stf_rom
    import short_preamble_gen_pkg::*;
(
    input  logic [IDX_WIDTH-1:0] idx,
    output stf_sample_t          data
);

    assign data.i = STF_I[idx];
    assign data.q = STF_Q[idx];

endmodule

// File: rtl/short_preamble_gen.sv
// 802.11a/g short training field generator: NUM_REP symbol repeats over valid/ready.
// Define STF_WINDOW_EN for a half-amplitude first sample and one extra tail sample.
module short_preamble_gen
    import short_preamble_gen_pkg::*;
#(
    parameter int unsigned NUM_REP      = 10,
    parameter int unsigned SAMPLE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      enable,
    input  logic                      start,
    input  logic                      abort,
    input  logic [1:0]                gain_shift,
    output logic [2*SAMPLE_WIDTH-1:0] sample_out,
    output logic                      sample_out_strobe,
    input  logic                      sample_out_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned SW = SAMPLE_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_SYM = IDX_WIDTH'(SYM_LEN - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_REP = IDX_WIDTH'(NUM_REP - 1);
`ifdef STF_WINDOW_EN
    localparam logic [SHF_WIDTH-1:0] WIN_SHIFT = SHF_WIDTH'(1);
`else
    localparam logic [SHF_WIDTH-1:0] WIN_SHIFT = SHF_WIDTH'(0);
`endif

    stf_state_e             state_q, state_d;
    logic [IDX_WIDTH-1:0]   sym_idx_q, sym_idx_d;
    logic [IDX_WIDTH-1:0]   rep_cnt_q, rep_cnt_d;
    logic [1:0]             shift_q, shift_d;
    logic [2*SW-1:0]        sample_d;
    logic                   strobe_d, busy_d, done_d;

    logic [IDX_WIDTH-1:0]   rom_idx_c;
    logic [SHF_WIDTH-1:0]   shift_amt_c;
    stf_sample_t            rom_data_c;
    logic [2*SW-1:0]        shaped_c;
    logic                   beat_c, last_c;

    assign beat_c = sample_out_strobe & sample_out_ready;
    assign last_c = (sym_idx_q == LAST_SYM) && (rep_cnt_q == LAST_REP);

    // Look up the sample to be presented after the coming edge
    always_comb begin
        rom_idx_c   = '0;
        shift_amt_c = {1'b0, shift_q};
        case (state_q)
            ST_IDLE: shift_amt_c = SHF_WIDTH'(gain_shift) + WIN_SHIFT;
            ST_RUN: begin
                rom_idx_c = sym_idx_q + IDX_WIDTH'(1);
                if (last_c) begin
                    shift_amt_c = {1'b0, shift_q} + WIN_SHIFT;
                end
            end
            default: ;
        endcase
    end

    stf_rom u_rom (
        .idx  (rom_idx_c),
        .data (rom_data_c)
    );

    assign shaped_c = {SW'(stf_shift(rom_data_c.i, shift_amt_c)),
                       SW'(stf_shift(rom_data_c.q, shift_amt_c))};

    // Next state and next registered outputs
    always_comb begin
        state_d   = state_q;
        sym_idx_d = sym_idx_q;
        rep_cnt_d = rep_cnt_q;
        shift_d   = shift_q;
        sample_d  = sample_out;
        strobe_d  = sample_out_strobe;
        busy_d    = busy;
        done_d    = done;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    sym_idx_d = '0;
                    rep_cnt_d = '0;
                    shift_d   = gain_shift;
                    sample_d  = shaped_c;
                    strobe_d  = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            ST_RUN: begin
                if (beat_c) begin
                    sym_idx_d = sym_idx_q + IDX_WIDTH'(1);
                    if (sym_idx_q == LAST_SYM) begin
                        rep_cnt_d = rep_cnt_q + IDX_WIDTH'(1);
                    end
                    if (!last_c) begin
                        sample_d = shaped_c;
                    end else begin
`ifdef STF_WINDOW_EN
                        state_d  = ST_TAIL;
                        sample_d = shaped_c;
`else
                        state_d  = ST_DONE;
                        sample_d = '0;
                        strobe_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
`endif
                    end
                end
            end
`ifdef STF_WINDOW_EN
            ST_TAIL: begin
                if (beat_c) begin
                    state_d  = ST_DONE;
                    sample_d = '0;
                    strobe_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides any beat, start or done in the same cycle
        if (abort) begin
            state_d  = ST_IDLE;
            sample_d = '0;
            strobe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q           <= ST_IDLE;
            sym_idx_q         <= '0;
            rep_cnt_q         <= '0;
            shift_q           <= '0;
            sample_out        <= '0;
            sample_out_strobe <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else if (enable) begin
            state_q           <= state_d;
            sym_idx_q         <= sym_idx_d;
            rep_cnt_q         <= rep_cnt_d;
            shift_q           <= shift_d;
            sample_out        <= sample_d;
            sample_out_strobe <= strobe_d;
            busy              <= busy_d;
            done              <= done_d;
        end
    end

endmodule

// File: tb/tb_short_preamble_gen.sv
// Self-checking bench for short_preamble_gen: vector table, corner sequences, random traffic vs model.
module tb_short_preamble_gen;

    localparam int NUM_REP = 10;
`ifdef STF_WINDOW_EN
    localparam int WIN = 1;
`else
    localparam int WIN = 0;
`endif
    localparam int LEN    = 16 * NUM_REP + WIN;
    localparam int BUDGET = 4 * LEN + 40;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic [1:0]  gain_shift = 2'd0;
    logic [31:0] s_out;
    logic        s_strobe, s_busy, s_done;

    always #5 clk = ~clk;

    short_preamble_gen #(.NUM_REP(NUM_REP), .SAMPLE_WIDTH(16)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .enable            (enable),
        .start             (start),
        .abort             (abort),
        .gain_shift        (gain_shift),
        .sample_out        (s_out),
        .sample_out_strobe (s_strobe),
        .sample_out_ready  (ready),
        .busy              (s_busy),
        .done              (s_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int TI [16] = '{377, -1081, -106, 1171, 754, 1171, -106, -1081,
                    377, 16, -647, -106, 0, -106, -647, 16};
    int TQ [16] = '{377, 16, -647, -106, 0, -106, -647, 16,
                    377, -1081, -106, 1171, 754, 1171, -106, -1081};

    // Reference model: burst position, not RTL state
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_pos  = 0;
    int          m_gain = 0;

    int          dut_beats = 0;
    int          done_cnt  = 0;
    logic [31:0] beats_q [$];
    logic [31:0] ref_q [$];
    logic [31:0] prev_sample = 32'd0;
    logic        prev_strobe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fdiv(input int v, input int s);
        int d = 1 << s;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic logic [31:0] exp_sample(input int pos, input int g);
        int sym = pos % 16;
        int s   = g;
        if (WIN == 1 && (pos == 0 || pos == LEN - 1)) s = g + 1;
        if (WIN == 1 && pos == LEN - 1) sym = 0;
        return {16'(fdiv(TI[sym], s)), 16'(fdiv(TQ[sym], s))};
    endfunction

    // Cycle monitor: advance model on each edge, compare outputs 1 time unit later
    initial begin
        forever begin
            @(posedge clk);
            if (rstn && enable && !abort && prev_strobe && ready) begin
                dut_beats++;
                beats_q.push_back(prev_sample);
            end
            if (!rstn) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                m_pos  = 0;
            end else if (enable) begin
                if (abort) begin
                    m_busy = 1'b0;
                    m_done = 1'b0;
                end else if (m_done) begin
                    m_done = 1'b0;
                end else if (!m_busy) begin
                    if (start) begin
                        m_busy = 1'b1;
                        m_pos  = 0;
                        m_gain = int'(gain_shift);
                    end
                end else if (ready) begin
                    if (m_pos == LEN - 1) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end else begin
                        m_pos++;
                    end
                end
            end
            #1;
            check("strobe", 32'(s_strobe), 32'(m_busy));
            check("busy", 32'(s_busy), 32'(m_busy));
            check("done", 32'(s_done), 32'(m_done));
            if (m_busy) check("sample", s_out, exp_sample(m_pos, m_gain));
            if (s_done === 1'b1) done_cnt++;
            prev_sample = s_out;
            prev_strobe = s_strobe;
        end
    end

    task automatic start_burst(input int g);
        dut_beats = 0;
        done_cnt  = 0;
        beats_q.delete();
        gain_shift = 2'(g);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gain_shift = ~2'(g);
    endtask

    // mode 0: ready high, 1: ready 1,0,0,1, 2: ready high with stray starts
    task automatic drive_until_done(input int mode);
        int cyc = 0;
        while (done_cnt == 0 && cyc < BUDGET) begin
            ready = (mode != 1) || (cyc % 4 == 0) || (cyc % 4 == 3);
            start = (mode == 2) && (cyc == 20 || cyc == 100);
            @(negedge clk);
            cyc++;
        end
        ready = 1'b1;
        start = (mode == 2);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("burst_len", 32'(dut_beats), 32'(LEN));
        check("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    task automatic wait_beats(input int n);
        int cyc = 0;
        while (dut_beats < n && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_beats", 32'(dut_beats), 32'(n));
    endtask

    typedef struct {
        int          g;
        int          beat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          diff;
        logic [31:0] got;
        logic [31:0] hold_s;

        vecs[0] = '{0, 0,       (WIN == 1) ? 32'h00BC_00BC : 32'h0179_0179};
        vecs[1] = '{0, 1,       32'hFBC7_0010};
        vecs[2] = '{0, 4,       32'h02F2_0000};
        vecs[3] = '{0, 16,      32'h0179_0179};
        vecs[4] = '{0, LEN - 1, (WIN == 1) ? 32'h00BC_00BC : 32'h0010_FBC7};
        vecs[5] = '{2, 0,       (WIN == 1) ? 32'h002F_002F : 32'h005E_005E};
        vecs[6] = '{2, 1,       32'hFEF1_0004};
        vecs[7] = '{3, 2,       32'hFFF2_FFAF};
        vecs[8] = '{3, 12,      32'h0000_005E};
        vecs[9] = '{1, 11,      32'hFFCB_0249};

        #2 rstn = 1'b0;
        enable = 1'b1;
        #1;
        check("rst_sample", s_out, 32'd0);
        check("rst_strobe", 32'(s_strobe), 32'd0);
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_done", 32'(s_done), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ready = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven vectors, one burst per gain group
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || vecs[i].g != vecs[i-1].g) begin
                start_burst(vecs[i].g);
                drive_until_done(0);
                if (vecs[i].g == 0) ref_q = beats_q;
            end
            got = (vecs[i].beat < beats_q.size()) ? beats_q[vecs[i].beat] : 32'hxxxx_xxxx;
            check($sformatf("vec%0d_g%0d_beat%0d", i, vecs[i].g, vecs[i].beat), got, vecs[i].exp);
        end

        // Backpressure and stray starts must reproduce the ready-high sequence
        for (int mode = 1; mode <= 2; mode++) begin
            start_burst(0);
            drive_until_done(mode);
            diff = (beats_q.size() == ref_q.size()) ? 0 : 1000;
            for (int i = 0; i < beats_q.size() && i < ref_q.size(); i++)
                if (beats_q[i] !== ref_q[i]) diff++;
            check($sformatf("seq_mode%0d", mode), 32'(diff), 32'd0);
        end

        // Abort on beat 37, restart two cycles later
        start_burst(0);
        wait_beats(37);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_strobe", 32'(s_strobe), 32'd0);
        check("abort_busy", 32'(s_busy), 32'd0);
        @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_beats", 32'(dut_beats), 32'd37);
        start_burst(0);
        check("restart_sample0", s_out, ref_q[0]);
        check("restart_strobe", 32'(s_strobe), 32'd1);
        drive_until_done(0);

        // Enable low freezes everything mid-burst
        start_burst(1);
        wait_beats(50);
        hold_s = s_out;
        enable = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check("hold_sample", s_out, hold_s);
        check("hold_strobe", 32'(s_strobe), 32'd1);
        check("hold_beats", 32'(dut_beats), 32'd50);
        enable = 1'b1;
        drive_until_done(0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ready      = ($urandom_range(0, 3) != 0);
            start      = ($urandom_range(0, 19) == 0);
            abort      = ($urandom_range(0, 299) == 0);
            enable     = ($urandom_range(0, 15) != 0);
            gain_shift = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        start  = 1'b0;
        enable = 1'b1;
        ready  = 1'b1;
        abort  = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-burst clears outputs immediately
        start_burst(0);
        wait_beats(20);
        #2 rstn = 1'b0;
        #1;
        check("arst_sample", s_out, 32'd0);
        check("arst_strobe", 32'(s_strobe), 32'd0);
        check("arst_busy", 32'(s_busy), 32'd0);
        check("arst_done", 32'(s_done), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
